enigma_ctrl: RTL and testbench

ENIGMA_CTRL -- requirements
Module: enigma_ctrl

---
 rtl/enigma_ctrl.sv | 156 +++++++++++++++
 tb/tb_enigma_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_ctrl.sv
// Job sequencer for an enigma core: streams rotor tables A and B, then message
// words, and returns counted core results to the host with an idle watchdog.
module enigma_ctrl #(
    parameter int TBL_DEPTH = 64,
    parameter int WDOG      = 16
) (
    input  logic       clk,
    input  logic       srst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] len,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    output logic       core_load,
    output logic       core_encrypt,
    output logic [1:0] core_table_idx,
    output logic       core_crypt_mode,
    output logic [5:0] core_code_in,
    input  logic       core_code_valid,
    input  logic [5:0] core_code_out,
    output logic       out_valid,
    output logic [5:0] out_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state
);

    // Handshake: a word moves on a rising edge where in_valid and in_ready are
    // both high; in_ready never depends on in_valid.

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, GAP, RUN, DRAIN, DONE
    } state_t;

    localparam int WD_W = $clog2(WDOG + 1);
    localparam logic [5:0]      IDX_LAST = 6'(TBL_DEPTH - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WDOG - 1);

    state_t          state, state_nxt;
    logic            mode_q;
    logic [7:0]      len_q;
    logic [5:0]      idx;
    logic [7:0]      sent;
    logic [7:0]      rcv;
    logic [7:0]      rcv_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            xfer;
    logic            loading;
    logic            rcv_hit;
    logic            err_hit;
    logic            wdog_fire;

    assign loading   = (state == LOAD_A) || (state == LOAD_B);
    assign in_ready  = loading || ((state == RUN) && (sent < len_q));
    assign xfer      = in_valid && in_ready;
    // Only results inside the job window are counted; anything else is a fault.
    assign rcv_hit   = core_code_valid && ((state == RUN) || (state == DRAIN)) && (rcv < len_q);
    assign err_hit   = core_code_valid && !rcv_hit;
    assign rcv_nxt   = rcv + {7'd0, rcv_hit};
    assign wdog_fire = (state == DRAIN) && !core_code_valid && (wd_cnt == WD_LAST)
                       && (rcv_nxt != len_q);

    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign err             = err_q;
    assign core_crypt_mode = mode_q;
    assign dbg_state       = state;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_A;
            LOAD_A:  if (xfer && (idx == IDX_LAST)) state_nxt = LOAD_B;
            LOAD_B:  if (xfer && (idx == IDX_LAST)) state_nxt = GAP;
            GAP:     state_nxt = (len_q == 8'd0) ? DONE : RUN;
            RUN:     if (xfer && ((sent + 8'd1) == len_q)) state_nxt = DRAIN;
            DRAIN:   if ((rcv_nxt == len_q) || wdog_fire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            mode_q         <= 1'b0;
            len_q          <= 8'd0;
            idx            <= 6'd0;
            sent           <= 8'd0;
            rcv            <= 8'd0;
            wd_cnt         <= '0;
            err_q          <= 1'b0;
            core_load      <= 1'b0;
            core_encrypt   <= 1'b0;
            core_table_idx <= 2'd3;
            core_code_in   <= 6'd0;
            out_valid      <= 1'b0;
            out_data       <= 6'd0;
        end else begin
            core_load    <= xfer && loading;
            core_encrypt <= xfer && (state == RUN);
            if (xfer && (state == LOAD_A)) begin
                core_table_idx <= 2'd1;
            end else if (xfer && (state == LOAD_B)) begin
                core_table_idx <= 2'd2;
            end else begin
                core_table_idx <= 2'd3;
            end
            if (xfer) begin
                core_code_in <= in_data;
            end
            out_valid <= rcv_hit;
            if (rcv_hit) begin
                out_data <= core_code_out;
            end

            if ((state == IDLE) && start) begin
                mode_q <= mode;
                len_q  <= len;
                idx    <= 6'd0;
                sent   <= 8'd0;
                rcv    <= 8'd0;
                wd_cnt <= '0;
                err_q  <= 1'b0;
            end else begin
                // Index restarts at 0 for each table.
                if (xfer && loading) begin
                    idx <= (idx == IDX_LAST) ? 6'd0 : idx + 6'd1;
                end
                if (xfer && (state == RUN)) begin
                    sent <= sent + 8'd1;
                end
                rcv <= rcv_nxt;
                if ((state == DRAIN) && !core_code_valid) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end else begin
                    wd_cnt <= '0;
                end
                if (err_hit || wdog_fire) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_enigma_ctrl.sv
// Bench for enigma_ctrl: host driver, behavioural two-rotor core, and a result
// scoreboard fed from golden values computed from the bench's own tables.
module tb_enigma_ctrl;

    logic       clk = 1'b0;
    logic       srst_n, start, mode, in_valid, in_ready;
    logic [7:0] len;
    logic [5:0] in_data;
    logic       core_load, core_encrypt, core_crypt_mode, core_code_valid;
    logic [1:0] core_table_idx;
    logic [5:0] core_code_in, core_code_out;
    logic       out_valid, busy, done, err;
    logic [5:0] out_data;
    logic [2:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    enigma_ctrl #(.TBL_DEPTH(64), .WDOG(16)) dut (
        .clk(clk), .srst_n(srst_n), .start(start), .mode(mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_load(core_load), .core_encrypt(core_encrypt),
        .core_table_idx(core_table_idx), .core_crypt_mode(core_crypt_mode),
        .core_code_in(core_code_in), .core_code_valid(core_code_valid),
        .core_code_out(core_code_out), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Host-side golden tables.
    logic [5:0] tbl_a[64], tbl_b[64];

    // Behavioural core: loads tables in arrival order, two-cycle result latency.
    logic [5:0] ca[64], cb[64], cai[64], cbi[64];
    logic [5:0] pa, pb;
    int         enc_cnt;
    int         withhold_idx = 0;
    logic       inj_valid = 1'b0;
    logic       s1_v = 1'b0, model_v = 1'b0;
    logic [5:0] s1_d = 6'd0, model_d = 6'd0;

    assign core_code_valid = model_v | inj_valid;
    assign core_code_out   = model_d;

    always @(posedge clk) begin
        if (!srst_n || !busy) begin
            pa = 6'd0;
            pb = 6'd0;
            enc_cnt = 0;
        end else if (core_load && core_table_idx == 2'd1) begin
            ca[pa] = core_code_in;
            cai[core_code_in] = pa;
            pa = pa + 6'd1;
        end else if (core_load && core_table_idx == 2'd2) begin
            cb[pb] = core_code_in;
            cbi[core_code_in] = pb;
            pb = pb + 6'd1;
        end
        if (srst_n && core_encrypt) begin
            enc_cnt++;
            s1_v <= (enc_cnt != withhold_idx);
            s1_d <= core_crypt_mode ? cai[cbi[core_code_in]] : cb[ca[core_code_in]];
        end else begin
            s1_v <= 1'b0;
        end
        model_v <= s1_v && srst_n;
        model_d <= s1_d;
    end

    // Monitor: strobe bookkeeping and scoreboard pops.
    int   cyc = 0;
    int   cnt_l1, cnt_l2, cnt_enc, cnt_out, cnt_done, strobe_err, mode_err;
    int   last_load_cyc, first_enc_cyc, last_out_cyc, done_cyc;
    logic err_at_done;
    logic cur_mode;
    logic prev_xfer = 1'b0;
    logic [5:0] prev_data;
    logic [5:0] e;

    always @(negedge clk) begin
        cyc++;
        if (core_load && core_table_idx == 2'd1) cnt_l1++;
        if (core_load && core_table_idx == 2'd2) cnt_l2++;
        if (core_load) last_load_cyc = cyc;
        if (core_encrypt) begin
            cnt_enc++;
            if (first_enc_cyc == 0) first_enc_cyc = cyc;
            if (core_table_idx !== 2'd3 || core_crypt_mode !== cur_mode) mode_err++;
        end
        if ((core_load | core_encrypt) !== prev_xfer) strobe_err++;
        else if (prev_xfer && core_code_in !== prev_data) strobe_err++;
        prev_xfer = in_valid & in_ready & srst_n;
        prev_data = in_data;
        if (done) begin
            cnt_done++;
            done_cyc = cyc;
            err_at_done = err;
        end
        if (out_valid) begin
            cnt_out++;
            last_out_cyc = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_unexpected: got %0d, required no result", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    miscompares++;
                    $display("FAIL out_data: got %0d, required %0d", out_data, e);
                end
            end
        end
    end

    bit drv_fail;

    task automatic gen_tables();
        logic [5:0] t;
        int j;
        for (int i = 0; i < 64; i++) begin
            tbl_a[i] = 6'(i);
            tbl_b[i] = 6'(i);
        end
        for (int i = 63; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = tbl_a[i]; tbl_a[i] = tbl_a[j]; tbl_a[j] = t;
            j = $urandom_range(i, 0);
            t = tbl_b[i]; tbl_b[i] = tbl_b[j]; tbl_b[j] = t;
        end
    endtask

    task automatic clear_stats();
        cnt_l1 = 0; cnt_l2 = 0; cnt_enc = 0; cnt_out = 0; cnt_done = 0;
        strobe_err = 0; mode_err = 0; last_load_cyc = 0; first_enc_cyc = 0;
        last_out_cyc = 0; done_cyc = 0; err_at_done = 1'bx; drv_fail = 0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [5:0] d, input bit bubble);
        bit ok;
        ok = 0;
        if (drv_fail) return;
        if (bubble) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!ok) begin
            drv_fail = 1;
            in_valid = 1'b0;
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: word %0d not accepted within 20 cycles", d);
        end
    endtask

    task automatic run_job(input bit m, input int n, input bit bub, input int wh, input int inj);
        int k;
        bit seen;
        logic [5:0] pt, ct;
        clear_stats();
        cur_mode = m;
        withhold_idx = wh;
        k = 0;
        gen_tables();
        start = 1'b1; mode = m; len = 8'(n);
        @(posedge clk); #1;
        mode = ~m;  // start stays high: must be ignored once the job is running
        for (int i = 0; i < 64; i++) begin
            if (i == inj) begin
                vectors++;
                if (err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL err_cleared_by_start: got %b, required 0", err);
                end
                inj_valid = 1'b1;
            end
            send_word(tbl_a[i], bub && (k % 3 == 2));
            inj_valid = 1'b0;
            k++;
        end
        for (int i = 0; i < 64; i++) begin
            send_word(tbl_b[i], bub && (k % 3 == 2));
            k++;
        end
        start = 1'b0; mode = m;
        for (int i = 0; i < n; i++) begin
            pt = 6'($urandom_range(63, 0));
            ct = tbl_b[tbl_a[pt]];
            exp_q.push_back(m ? pt : ct);
            send_word(m ? ct : pt, bub && (k % 3 == 2));
            k++;
        end
        in_valid = 1'b0;
        seen = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_timeout: no done within 400 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        srst_n = 1'b0; start = 1'b0; mode = 1'b0; len = 8'd0;
        in_valid = 1'b0; in_data = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({in_ready, busy, done, err} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, required 0000", {in_ready, busy, done, err});
        end
        vectors++;
        if ({core_load, core_encrypt, core_table_idx, core_crypt_mode, core_code_in} !== 11'b00_11_0_000000) begin
            miscompares++;
            $display("FAIL reset_core: got %b, required 00110000000",
                     {core_load, core_encrypt, core_table_idx, core_crypt_mode, core_code_in});
        end
        vectors++;
        if ({out_valid, out_data} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_out: got %b, required 0000000", {out_valid, out_data});
        end
        @(posedge clk); #1;
        srst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encrypt();
        run_job(1'b0, 27, 1'b0, 0, -1);
        vectors++;
        if ({cnt_l1, cnt_l2} !== {32'd64, 32'd64}) begin
            miscompares++;
            $display("FAIL enc_loads: got %0d/%0d, required 64/64", cnt_l1, cnt_l2);
        end
        vectors++;
        if ({cnt_enc, cnt_out, cnt_done} !== {32'd27, 32'd27, 32'd1}) begin
            miscompares++;
            $display("FAIL enc_counts: got enc %0d out %0d done %0d, required 27/27/1", cnt_enc, cnt_out, cnt_done);
        end
        vectors++;
        if (first_enc_cyc - last_load_cyc !== 2) begin
            miscompares++;
            $display("FAIL enc_gap: got %0d, required 2", first_enc_cyc - last_load_cyc);
        end
        vectors++;
        if ({strobe_err, mode_err} !== 64'd0) begin
            miscompares++;
            $display("FAIL enc_strobes: got %0d/%0d bad, required 0/0", strobe_err, mode_err);
        end
        vectors++;
        if (err !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL enc_end: got err %b left %0d, required 0/0", err, exp_q.size());
        end
    endtask

    task automatic test_decrypt_bubbles();
        run_job(1'b1, 112, 1'b1, 0, -1);
        vectors++;
        if ({cnt_l1, cnt_l2, cnt_enc, cnt_out} !== {32'd64, 32'd64, 32'd112, 32'd112}) begin
            miscompares++;
            $display("FAIL dec_counts: got %0d/%0d/%0d/%0d, required 64/64/112/112", cnt_l1, cnt_l2, cnt_enc, cnt_out);
        end
        vectors++;
        if ({strobe_err, mode_err} !== 64'd0) begin
            miscompares++;
            $display("FAIL dec_strobes: got %0d/%0d bad, required 0/0", strobe_err, mode_err);
        end
        vectors++;
        if (err !== 1'b0 || cnt_done !== 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL dec_end: got err %b done %0d left %0d, required 0/1/0", err, cnt_done, exp_q.size());
        end
    endtask

    task automatic test_len_zero();
        run_job(1'b0, 0, 1'b0, 0, -1);
        vectors++;
        if ({cnt_l1, cnt_l2, cnt_enc, cnt_out, cnt_done} !== {32'd64, 32'd64, 32'd0, 32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL len0_counts: got %0d/%0d/%0d/%0d/%0d, required 64/64/0/0/1",
                     cnt_l1, cnt_l2, cnt_enc, cnt_out, cnt_done);
        end
        vectors++;
        if (done_cyc - last_load_cyc !== 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_done: got spacing %0d err %b, required 1/0", done_cyc - last_load_cyc, err);
        end
    endtask

    task automatic test_watchdog();
        run_job(1'b0, 5, 1'b0, 5, -1);
        withhold_idx = 0;
        vectors++;
        if ({cnt_enc, cnt_out, cnt_done} !== {32'd5, 32'd4, 32'd1}) begin
            miscompares++;
            $display("FAIL wdog_counts: got enc %0d out %0d done %0d, required 5/4/1", cnt_enc, cnt_out, cnt_done);
        end
        vectors++;
        if (done_cyc - last_out_cyc !== 16) begin
            miscompares++;
            $display("FAIL wdog_delay: got %0d, required 16", done_cyc - last_out_cyc);
        end
        vectors++;
        if (err_at_done !== 1'b1 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL wdog_err: got %b/%b, required 1/1", err_at_done, err);
        end
        vectors++;
        if (exp_q.size() != 1) begin
            miscompares++;
            $display("FAIL wdog_pending: got %0d, required 1", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_inject();
        run_job(1'b0, 3, 1'b0, 0, 10);
        vectors++;
        if (err_at_done !== 1'b1 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL inj_err_sticky: got %b/%b, required 1/1", err_at_done, err);
        end
        vectors++;
        if (cnt_out !== 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL inj_results: got %0d left %0d, required 3/0", cnt_out, exp_q.size());
        end
        run_job(1'b1, 0, 1'b0, 0, -1);
        vectors++;
        if (err !== 1'b0 || cnt_done !== 1) begin
            miscompares++;
            $display("FAIL inj_err_clear: got err %b done %0d, required 0/1", err, cnt_done);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        gen_tables();
        start = 1'b1; mode = 1'b1; len = 8'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) send_word(tbl_a[i], 1'b0);
        for (int i = 0; i < 30; i++) send_word(tbl_b[i], 1'b0);
        in_valid = 1'b1; in_data = 6'd42;
        srst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({in_ready, busy, done, err} !== 4'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl: got %b, required 0000", {in_ready, busy, done, err});
        end
        vectors++;
        if ({core_load, core_encrypt, core_table_idx, core_crypt_mode, core_code_in} !== 11'b00_11_0_000000) begin
            miscompares++;
            $display("FAIL mid_reset_core: got %b, required 00110000000",
                     {core_load, core_encrypt, core_table_idx, core_crypt_mode, core_code_in});
        end
        vectors++;
        if ({out_valid, out_data} !== 7'b0) begin
            miscompares++;
            $display("FAIL mid_reset_out: got %b, required 0000000", {out_valid, out_data});
        end
        @(posedge clk); #1;
        srst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        run_job(1'b0, 8, 1'b0, 0, -1);
        vectors++;
        if ({cnt_l1, cnt_l2, cnt_out} !== {32'd64, 32'd64, 32'd8} || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_reload: got %0d/%0d/%0d left %0d, required 64/64/8/0",
                     cnt_l1, cnt_l2, cnt_out, exp_q.size());
        end
        vectors++;
        if (strobe_err !== 0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reload_strobes: got %0d bad err %b, required 0/0", strobe_err, err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt_bubbles();
        test_len_zero();
        test_watchdog();
        test_inject();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
